// File: rtl/booth_mult_seq_if.sv
// Booth action interface between the multiplier controller and the
// combinational partial-product generator / requesting logic.
interface booth_mult_seq_if;
  logic       start;
  logic [7:0] multiplicand;
  logic [7:0] multiplier;
  logic [7:0] mcand_q;
  logic [2:0] action;
  logic [9:0] pp;
  logic       busy;
  logic       done;
  logic [15:0] product;

  // Requester plus partial-product generator side.
  modport master (
    output start, multiplicand, multiplier, pp,
    input  mcand_q, action, busy, done, product
  );

  // Controller side.
  modport slave (
    input  start, multiplicand, multiplier, pp,
    output mcand_q, action, busy, done, product
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier controller: 8x8 unsigned -> 16.
// Scans the multiplier two bits per cycle and emits one registered Booth
// action per group; the external generator returns the partial product
// in the same cycle, and it is accumulated at weight 4^cnt.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | five group cycles, cnt = 0..4
// DONE  | one-cycle done pulse, product valid
module booth_mult_seq (
  input  logic            clk,
  input  logic            rst,
  booth_mult_seq_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state;
  logic [7:0]  mult_q;
  logic [7:0]  mcand_r;
  logic [2:0]  action_r;
  logic [2:0]  cnt;
  logic [17:0] acc;
  logic [15:0] product_r;
  logic [17:0] pp_ext;
  logic [17:0] pp_shift;
  logic [17:0] acc_next;

  // Booth recoding of a 3-bit group (y[2i+1], y[2i], y[2i-1]).
  function automatic logic [2:0] encode(input logic [2:0] grp);
    logic [2:0] a;
    case (grp)
      3'b000:  a = 3'b000;
      3'b001:  a = 3'b010;
      3'b010:  a = 3'b010;
      3'b011:  a = 3'b100;
      3'b100:  a = 3'b101;
      3'b101:  a = 3'b011;
      3'b110:  a = 3'b011;
      default: a = 3'b000;
    endcase
    return a;
  endfunction

  // Group idx of the multiplier, with y[-1] = y[8] = y[9] = 0.
  function automatic logic [2:0] group_of(input logic [7:0] y, input logic [2:0] idx);
    logic [10:0] ext;
    ext = {2'b00, y, 1'b0};
    return ext[{idx, 1'b0} +: 3];
  endfunction

  // Sign-extend the returned partial product and weight it by 4^cnt.
  always_comb begin
    pp_ext   = {{8{bus.pp[9]}}, bus.pp};
    pp_shift = pp_ext << {cnt, 1'b0};
    acc_next = acc + pp_shift;
  end

  // Sequencer, operand latches, action register and accumulator.
  // A start seen in DONE is accepted directly so back-to-back requests
  // complete every six cycles; it does not disturb the pulse in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mult_q    <= 8'h00;
      mcand_r   <= 8'h00;
      action_r  <= 3'b000;
      cnt       <= 3'd0;
      acc       <= 18'd0;
      product_r <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            mcand_r  <= bus.multiplicand;
            mult_q   <= bus.multiplier;
            acc      <= 18'd0;
            cnt      <= 3'd0;
            action_r <= encode(group_of(bus.multiplier, 3'd0));
            state    <= ST_RUN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          acc <= acc_next;
          if (cnt == 3'd4) begin
            product_r <= acc_next[15:0];
            action_r  <= 3'b000;
            state     <= ST_DONE;
          end else begin
            cnt      <= cnt + 3'd1;
            action_r <= encode(group_of(mult_q, cnt + 3'd1));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mcand_q = mcand_r;
  assign bus.action  = action_r;
  assign bus.product = product_r;
  assign bus.busy    = (state == ST_RUN);
  assign bus.done    = (state == ST_DONE);

endmodule
